// File: rtl/scan_seq.sv
// Channel scan sequencer: steps a 2-to-4 decoder select through the enabled mask bits with a programmable dwell.
// Optional macro SCAN_BLANK_EN inserts one BLANK cycle (decoder disabled) before every DRIVE entry.
module scan_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    mask,
  input  logic [DW-1:0] dwell,
  output logic [1:0]    sel,
  output logic          sel_en,
  output logic          busy,
  output logic          frame_done
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  localparam state_t ENTRY = BLANK;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
  localparam state_t ENTRY = DRIVE;
`endif

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          selEn_q, selEn_d;
  logic          busy_q, busy_d;
  logic          frameDone_q, frameDone_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          stop_q, stop_d;
  logic [3:0]    maskSnap_q, maskSnap_d;
  logic [DW-1:0] dwellSnap_q, dwellSnap_d;

  logic [2:0]    nextInfo;
  logic [1:0]    lowestNew;
  logic          terminal;
  logic          stopNow;
  logic          wrapEvent;

  function automatic logic [1:0] lowestSet(input logic [3:0] m);
    lowestSet = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowestSet = 2'(i);
  endfunction

  // {found, index} of the lowest set bit strictly above the current channel
  function automatic logic [2:0] nextAbove(input logic [3:0] m, input logic [1:0] c);
    nextAbove = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(c))) nextAbove = {1'b1, 2'(i)};
  endfunction

  assign nextInfo  = nextAbove(maskSnap_q, sel_q);
  assign lowestNew = lowestSet(mask);
  assign terminal  = (cnt_q == dwellSnap_q);
  assign stopNow   = stop_q | stop;
  assign wrapEvent = (state_q == DRIVE) && terminal && !nextInfo[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      selEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      cnt_q       <= '0;
      stop_q      <= 1'b0;
      maskSnap_q  <= '0;
      dwellSnap_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      selEn_q     <= selEn_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      maskSnap_q  <= maskSnap_d;
      dwellSnap_q <= dwellSnap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    stop_d      = stop_q;
    maskSnap_d  = maskSnap_q;
    dwellSnap_d = dwellSnap_q;
    case (state_q)
      IDLE: begin
        if (start && !stop && (mask != 4'd0)) begin
          maskSnap_d  = mask;
          dwellSnap_d = dwell;
          sel_d       = lowestNew;
          cnt_d       = '0;
          stop_d      = 1'b0;
          state_d     = ENTRY;
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        cnt_d   = '0;
        state_d = DRIVE;
      end
`endif
      DRIVE: begin
        if (!terminal) begin
          cnt_d  = cnt_q + DW'(1);
          stop_d = stopNow;
        end else begin
          cnt_d = '0;
          // A wrap always refreshes the snapshots, even when the pass ends the scan
          if (!nextInfo[2]) begin
            maskSnap_d  = mask;
            dwellSnap_d = dwell;
          end
          if (stopNow) begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end else if (nextInfo[2]) begin
            sel_d   = nextInfo[1:0];
            state_d = ENTRY;
          end else if (mask == 4'd0) begin
            state_d = IDLE;
          end else begin
            sel_d   = lowestNew;
            state_d = ENTRY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    selEn_d     = (state_d == DRIVE);
    busy_d      = (state_d != IDLE);
    frameDone_d = wrapEvent;
  end

  assign sel        = sel_q;
  assign sel_en     = selEn_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_scan_seq.sv
// Scoreboard bench for scan_seq in its default build (SCAN_BLANK_EN undefined).
// Each stimulus call pushes the expected {sel, sel_en, busy, frame_done} for the following edge.
module tb_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic [1:0] sel;
  logic       sel_en;
  logic       busy;
  logic       frame_done;

  int compareCount = 0;
  int errorCount   = 0;

  logic [4:0] expQ[$];
  string      tagQ[$];

  scan_seq #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mask      (mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_en    (sel_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ex(input logic [1:0] s, input logic en, input logic b, input logic fd);
    ex = {s, en, b, fd};
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    compareCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: sel/en/busy/fd got %b_%b%b%b required %b_%b%b%b", tag,
               observed[4:3], observed[2], observed[1], observed[0],
               expected[4:3], expected[2], expected[1], expected[0]);
    end
  endtask

  // Drive inputs, push the expectation, then pop it once the edge's result is visible
  task automatic applyStimulus(input string tag, input logic r, input logic s, input logic p,
                               input logic [3:0] m, input logic [7:0] d, input logic [4:0] expected);
    logic [4:0] e;
    string      t;
    rst   = r;
    start = s;
    stop  = p;
    mask  = m;
    dwell = d;
    expQ.push_back(expected);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput(t, {sel, sel_en, busy, frame_done}, e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 4'd0; dwell = 8'd0;

    applyStimulus("reset0", 1, 0, 0, 4'b0000, 8'd0, ex(0, 0, 0, 0));
    applyStimulus("reset1", 1, 1, 0, 4'b1011, 8'd1, ex(0, 0, 0, 0));
    applyStimulus("idle",   0, 0, 0, 4'b1011, 8'd1, ex(0, 0, 0, 0));

    // mask 1011, dwell 1
    applyStimulus("m1011_c0", 0, 1, 0, 4'b1011, 8'd1, ex(0, 1, 1, 0));
    applyStimulus("m1011_c1", 0, 0, 0, 4'b1011, 8'd1, ex(0, 1, 1, 0));
    applyStimulus("m1011_c2", 0, 0, 0, 4'b1011, 8'd1, ex(1, 1, 1, 0));
    applyStimulus("m1011_c3", 0, 0, 0, 4'b1011, 8'd1, ex(1, 1, 1, 0));
    applyStimulus("m1011_c4", 0, 0, 0, 4'b1011, 8'd1, ex(3, 1, 1, 0));
    applyStimulus("m1011_c5", 0, 0, 0, 4'b1011, 8'd1, ex(3, 1, 1, 0));
    applyStimulus("m1011_wrap", 0, 0, 0, 4'b1011, 8'd1, ex(0, 1, 1, 1));
    applyStimulus("m1011_c7", 0, 0, 0, 4'b1011, 8'd1, ex(0, 1, 1, 0));
    applyStimulus("m1011_stop_tc", 0, 0, 1, 4'b1011, 8'd1, ex(0, 0, 0, 0));

    // single-bit mask 0100, dwell 2
    applyStimulus("m0100_c0", 0, 1, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_c1", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_c2", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_wrap1", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 1));
    applyStimulus("m0100_c4", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_c5", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_wrap2", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 1));
    applyStimulus("m0100_stop_latch", 0, 0, 1, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_latched", 0, 0, 0, 4'b0100, 8'd2, ex(2, 1, 1, 0));
    applyStimulus("m0100_stop_wrap", 0, 0, 0, 4'b0100, 8'd2, ex(2, 0, 0, 1));
    applyStimulus("m0100_idle", 0, 0, 0, 4'b0100, 8'd2, ex(2, 0, 0, 0));

    // ignored starts in IDLE keep all outputs, including sel
    applyStimulus("start_mask0", 0, 1, 0, 4'b0000, 8'd2, ex(2, 0, 0, 0));
    applyStimulus("start_with_stop", 0, 1, 1, 4'b0011, 8'd2, ex(2, 0, 0, 0));

    // dwell 5, stop on the second DRIVE cycle, start pulse while busy
    applyStimulus("d5_c0", 0, 1, 0, 4'b0011, 8'd5, ex(0, 1, 1, 0));
    applyStimulus("d5_stop", 0, 0, 1, 4'b0011, 8'd5, ex(0, 1, 1, 0));
    applyStimulus("d5_busy_start", 0, 1, 0, 4'b0011, 8'd5, ex(0, 1, 1, 0));
    for (int i = 3; i < 6; i++)
      applyStimulus($sformatf("d5_c%0d", i), 0, 0, 0, 4'b0011, 8'd5, ex(0, 1, 1, 0));
    applyStimulus("d5_end", 0, 0, 0, 4'b0011, 8'd5, ex(0, 0, 0, 0));
    applyStimulus("d5_idle", 0, 0, 0, 4'b0011, 8'd5, ex(0, 0, 0, 0));

    // mask changes mid-frame take effect only at the wrap
    applyStimulus("mchg_c0", 0, 1, 0, 4'b1111, 8'd0, ex(0, 1, 1, 0));
    applyStimulus("mchg_c1", 0, 0, 0, 4'b0010, 8'd0, ex(1, 1, 1, 0));
    applyStimulus("mchg_c2", 0, 0, 0, 4'b0010, 8'd0, ex(2, 1, 1, 0));
    applyStimulus("mchg_c3", 0, 0, 0, 4'b0010, 8'd0, ex(3, 1, 1, 0));
    applyStimulus("mchg_wrap1", 0, 0, 0, 4'b0010, 8'd0, ex(1, 1, 1, 1));
    applyStimulus("mchg_wrap2", 0, 0, 0, 4'b0010, 8'd0, ex(1, 1, 1, 1));
    applyStimulus("mchg_mask0", 0, 0, 0, 4'b0000, 8'd0, ex(1, 0, 0, 1));
    applyStimulus("mchg_idle", 0, 0, 0, 4'b0000, 8'd0, ex(1, 0, 0, 0));

    // reset mid-DRIVE with start high, then restart
    applyStimulus("rst_c0", 0, 1, 0, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_c1", 0, 0, 0, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_mid", 1, 1, 0, 4'b0110, 8'd3, ex(0, 0, 0, 0));
    applyStimulus("rst_restart", 0, 1, 0, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_c1b", 0, 0, 0, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_stop", 0, 0, 1, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_tc", 0, 0, 0, 4'b0110, 8'd3, ex(1, 1, 1, 0));
    applyStimulus("rst_end", 0, 0, 0, 4'b0110, 8'd3, ex(1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
